hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the 5-stage core. Watches the instruction held in the IF/ID register, the load in ID/EX, the branch resolution in EX and the data-memory busy flag. Drives the PC write-enable, the IF/ID write-enable and flush, and the ID/EX bubble and freeze controls. Keeps saturating stall and flush counters and a data-memory timeout watchdog.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/sat_counter.sv | 26 ++
 rtl/hazard_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, opcodes, field slices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    // Debug class of the previous cycle, as shown on the state output
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_FREEZE = 2'd3
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;

    // rt is a true source only for R-type, stores and the two compare-branches;
    // for loads/immediates it is the destination and must not raise a hazard
    function automatic logic uses_rt(input logic [5:0] opc);
        return (opc == OP_RTYPE) || (opc == OP_SW) ||
               (opc == OP_BEQ)   || (opc == OP_BNE);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all ones.
// Latency: count visible one clock after the inc cycle.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // Count up on inc, hold once every bit is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stall, branch flush, dmem freeze, watchdog.
// Latency: controls are combinational (zero-cycle); state/counters/timeout update on the next edge.
// Backpressure: dmem_busy freezes the whole pipe and overrides every other request.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             pc_sel_branch,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [5:0]        w_opc;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic              w_load_use;
    logic              w_unused_imm;
    state_e            w_cls;
    state_e            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_timeout;

    assign w_opc        = id_instr[OPC_HI:OPC_LO];
    assign w_rs         = id_instr[RS_HI:RS_LO];
    assign w_rt         = id_instr[RT_HI:RT_LO];
    assign w_unused_imm = ^id_instr[15:0];

    // rs is always a source; a $zero destination never creates a dependency
    assign w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                        ((w_rs == ex_rt) || (uses_rt(w_opc) && (w_rt == ex_rt)));

    // Classify this cycle: memory freeze beats branch beats load-use
    always_comb begin
        w_cls = ST_RUN;
        if (dmem_busy) begin
            w_cls = ST_FREEZE;
        end else if (ex_branch_taken) begin
            w_cls = ST_FLUSH;
        end else if (w_load_use) begin
            w_cls = ST_STALL;
        end
    end

    // Drive pipeline controls from the class; everything is held low during reset
    always_comb begin
        pc_write      = 1'b0;
        pc_sel_branch = 1'b0;
        ifid_write    = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        pipe_freeze   = 1'b0;
        if (!rst) begin
            unique case (w_cls)
                ST_FREEZE: begin
                    pipe_freeze = 1'b1;
                end
                ST_FLUSH: begin
                    pc_write      = 1'b1;
                    pc_sel_branch = 1'b1;
                    ifid_write    = 1'b1;
                    ifid_flush    = 1'b1;
                    idex_flush    = 1'b1;
                end
                ST_STALL: begin
                    idex_flush = 1'b1;
                end
                default: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
            endcase
        end
    end

    // Record the class for debug and run the dmem watchdog (sticky until reset)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_cls;
            if (dmem_busy) begin
                if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
                    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                end
                if (r_wait_cnt >= WAIT_W'(MAX_WAIT - 1)) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // Freeze cycles and load-use bubbles both count as lost cycles
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc ((w_cls == ST_STALL) || (w_cls == ST_FREEZE)),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_cls == ST_FLUSH),
        .cnt (flush_cnt)
    );

    assign state       = r_state;
    assign mem_timeout = r_mem_timeout;

endmodule
